// File: rtl/pr_arbiter_if.sv
// Handshake bundle between N requesters and the pr_arbiter.
//
// Signals:
//   req      requesters -> arbiter  level request vector, one bit per requester
//   rr_mode  requesters -> arbiter  0 = fixed priority, 1 = round-robin
//   done     requesters -> arbiter  holder releases its grant (1-cycle pulse)
//   gnt      arbiter -> requesters  one-hot grant
//   gnt_id   arbiter -> requesters  binary index of the holder, 0 when none
//   gnt_vld  arbiter -> requesters  a grant is held
//   idle     arbiter -> requesters  arbiter FSM is idle
//   timeout  arbiter -> requesters  forced-release pulse (PR_ARB_TIMEOUT_EN only)
//
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: PR_ARB_TIMEOUT_EN adds the timeout signal.
interface pr_arbiter_if #(
  parameter int N = 8
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic           rr_mode;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           idle;
`ifdef PR_ARB_TIMEOUT_EN
  logic           timeout;

  modport master (
    output req, rr_mode, done,
    input  gnt, gnt_id, gnt_vld, idle, timeout
  );

  modport slave (
    input  req, rr_mode, done,
    output gnt, gnt_id, gnt_vld, idle, timeout
  );
`else
  modport master (
    output req, rr_mode, done,
    input  gnt, gnt_id, gnt_vld, idle
  );

  modport slave (
    input  req, rr_mode, done,
    output gnt, gnt_id, gnt_vld, idle
  );
`endif
endinterface

// File: rtl/pr_arbiter.sv
// Registered N-way priority arbiter with run-time fixed / round-robin priority.
// Grants one requester, holds the grant until the holder pulses done or drops
// its request, and re-arbitrates on the release edge without a dead cycle.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   arb   pr_arbiter_if.slave  (req, rr_mode, done in; gnt, gnt_id, gnt_vld,
//         idle, and timeout when enabled, out)
//
// Parameters:
//   N        number of requesters (>=2); index N-1 is highest fixed priority
//   TIMEOUT  max grant length in cycles (>=1), only with PR_ARB_TIMEOUT_EN
//
// Optional feature macro: PR_ARB_TIMEOUT_EN enables the grant-length limit
// and the timeout pulse output.
module pr_arbiter #(
  parameter int N = 8
`ifdef PR_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input logic         clk,
  input logic         rst,
  pr_arbiter_if.slave arb
);
  localparam int IDW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic           found;
    logic [IDW-1:0] id;
  } pick_t;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   cand;
  pick_t          win;
  logic           release_evt;
  logic           new_grant;
  logic           expire;

  // Fixed mode scans from N-1 downwards; round-robin scans from ptr downwards
  // and wraps from 0 to N-1.
  function automatic pick_t pick(input logic [N-1:0]   c,
                                 input logic           rr,
                                 input logic [IDW-1:0] ptr);
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (rr) begin
        j = int'(ptr) - i;
        if (j < 0) j = j + N;
      end else begin
        j = N - 1 - i;
      end
      if (!p.found && c[IDW'(j)]) begin
        p.found = 1'b1;
        p.id    = IDW'(j);
      end
    end
    return p;
  endfunction

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    new_grant   = 1'b0;
    release_evt = 1'b0;
    cand        = arb.req;

    if (state_q == GRANT) begin
      // The releasing holder is excluded so a still-raised req cannot re-win.
      cand        = arb.req & ~gnt_q;
      release_evt = arb.done | ~arb.req[gnt_id_q] | expire;
    end

    win = pick(cand, arb.rr_mode, ptr_q);

    if (state_q == IDLE || release_evt) begin
      if (win.found) begin
        new_grant = 1'b1;
        state_d   = GRANT;
        gnt_d     = N'(1) << win.id;
        gnt_id_d  = win.id;
        // The winner becomes lowest priority for the next round-robin search.
        if (arb.rr_mode) begin
          ptr_d = (win.id == '0) ? IDW'(N - 1) : win.id - IDW'(1);
        end
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= IDW'(N - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef PR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // cnt_q counts completed grant cycles minus one; at TIMEOUT-1 the holder
  // has held for TIMEOUT cycles and is released at this edge.
  assign expire = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (!new_grant && state_q == GRANT && !release_evt) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  assign arb.timeout = timeout_q;
`else
  assign expire = 1'b0;
`endif

  assign arb.gnt     = gnt_q;
  assign arb.gnt_id  = gnt_id_q;
  assign arb.gnt_vld = |gnt_q;
  assign arb.idle    = (state_q == IDLE);

endmodule

// File: tb/tb_pr_arbiter.sv
// Directed bench for pr_arbiter (N=8). Each step drives inputs, pushes the
// expected post-edge outputs to a scoreboard queue, and pops/compares them
// 1 ns after the rising edge. With PR_ARB_TIMEOUT_EN the DUT is built with
// TIMEOUT=4 and the forced-release sequence is exercised as well.
module tb_pr_arbiter;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
    string      tag;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;

  pr_arbiter_if #(.N(8)) bus ();

`ifdef PR_ARB_TIMEOUT_EN
  pr_arbiter #(.N(8), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );
`else
  pr_arbiter #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic expect_out(input logic [7:0] eg, input logic [2:0] eid,
                            input logic eto, input string tag);
    exp_t e;
    e.gnt = eg;
    e.id  = eid;
    e.to  = eto;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: no expected entry to compare");
      return;
    end
    e = sb.pop_front();

    checks++;
    assert (bus.gnt === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt: got %h expected %h", e.tag, bus.gnt, e.gnt);
    end
    checks++;
    assert (bus.gnt_id === e.id) else begin
      errors++;
      $error("FAIL %s gnt_id: got %0d expected %0d", e.tag, bus.gnt_id, e.id);
    end
    checks++;
    assert (bus.gnt_vld === (e.gnt != 8'h00)) else begin
      errors++;
      $error("FAIL %s gnt_vld: got %b expected %b", e.tag, bus.gnt_vld, (e.gnt != 8'h00));
    end
    checks++;
    assert (bus.idle === (e.gnt == 8'h00)) else begin
      errors++;
      $error("FAIL %s idle: got %b expected %b", e.tag, bus.idle, (e.gnt == 8'h00));
    end
    checks++;
    assert ($onehot0(bus.gnt) === 1'b1) else begin
      errors++;
      $error("FAIL %s onehot: got gnt %h expected at most one bit set", e.tag, bus.gnt);
    end
`ifdef PR_ARB_TIMEOUT_EN
    checks++;
    assert (bus.timeout === e.to) else begin
      errors++;
      $error("FAIL %s timeout: got %b expected %b", e.tag, bus.timeout, e.to);
    end
`endif
  endtask

  // Drive one cycle of stimulus, record the expected post-edge outputs,
  // then sample just after the edge.
  task automatic step(input logic [7:0] r, input logic rr, input logic d,
                      input logic [7:0] eg, input logic [2:0] eid,
                      input logic eto, input string tag);
    bus.req     = r;
    bus.rr_mode = rr;
    bus.done    = d;
    expect_out(eg, eid, eto, tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    bus.req     = 8'h00;
    bus.rr_mode = 1'b0;
    bus.done    = 1'b0;

    // Reset state, held across a few edges.
    repeat (3) @(posedge clk);
    #1;
    expect_out(8'h00, 3'd0, 1'b0, "reset_state");
    compare();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fixed priority chain with back-to-back re-arbitration.
    step(8'h25, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0, "fix_first");
    step(8'h05, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0, "fix_b2b_2");
    step(8'h01, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0, "fix_b2b_0");
    step(8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, "fix_release");
    step(8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, "done_in_idle");

    // Round-robin sweep from the reset pointer, wrapping back to 7.
    for (int k = 7; k >= 0; k--) begin
      step(8'hFF, 1'b1, 1'b1, 8'(1 << k), 3'(k), 1'b0, $sformatf("rr_%0d", k));
    end
    step(8'hFF, 1'b1, 1'b1, 8'h80, 3'd7, 1'b0, "rr_wrap");
    step(8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, "rr_release");

    // Holder keeps the grant while a higher non-holder arrives, then release
    // by request drop without done.
    step(8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0, "drop_grant");
    step(8'h88, 1'b1, 1'b0, 8'h08, 3'd3, 1'b0, "hold_ignore_nonholder");
    step(8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "drop_release");
    step(8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0, "drop_regrant");
    step(8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, "drop_done");

    // Round-robin grant on 6 moves ptr to 5; async reset must restore ptr=7.
    step(8'h40, 1'b1, 1'b0, 8'h40, 3'd6, 1'b0, "rst_pre_grant");
    #2;
    rst = 1'b1;
    #1;
    expect_out(8'h00, 3'd0, 1'b0, "rst_async");
    compare();
    #3;
    rst = 1'b0;
    step(8'hFF, 1'b1, 1'b0, 8'h80, 3'd7, 1'b0, "rst_ptr_restored");
    step(8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, "rst_post_release");

`ifdef PR_ARB_TIMEOUT_EN
    // TIMEOUT=4: four grant cycles, then a forced release with a pulse,
    // then the same requester wins again from IDLE.
    step(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "to_c1");
    step(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "to_c2");
    step(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "to_c3");
    step(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "to_c4");
    step(8'h02, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, "to_forced");
    step(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "to_regrant");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
